data_packet_tx: RTL and testbench

//  Reader/transmit end of the DataCapture transfer FIFO. Pops accumulated 16-bit samples
//  (dataRead/dataValid/dataOut), frames one record as a byte packet and hands bytes to the

---
 rtl/data_link_pkg.sv | 22 ++
 rtl/data_packet_tx.sv | 165 ++++++++++++++++
 tb/tb_data_packet_tx.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_link_pkg.sv
// Shared definitions for the DataCapture-to-host byte link: packet constants,
// field widths and the one-hot transmit FSM encoding.
package data_link_pkg;

   localparam logic [7:0] DEFAULT_HDR_BYTE  = 8'hA5;
   localparam int         DEFAULT_STALL_MAX = 1023;
   localparam int         LEN_W             = 7;
   localparam int         SAMPLE_W          = 16;

   typedef enum logic [8:0] {
      S_IDLE    = 9'b000000001,
      S_HDR     = 9'b000000010,
      S_LEN     = 9'b000000100,
      S_EVT     = 9'b000001000,
      S_FETCH   = 9'b000010000,
      S_WAITV   = 9'b000100000,
      S_SEND_HI = 9'b001000000,
      S_SEND_LO = 9'b010000000,
      S_CSUM    = 9'b100000000
   } txState_e;

endpackage

// File: rtl/data_packet_tx.sv
// Pops 16-bit samples from the capture FIFO and frames them as
// HDR, LEN, EVT, payload bytes, CSUM for the byte transmitter.
module data_packet_tx
   import data_link_pkg::*;
#(
   parameter logic [7:0] HDR_BYTE  = DEFAULT_HDR_BYTE,
   parameter int         STALL_MAX = DEFAULT_STALL_MAX
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                dataReadyToRead,
   input  logic                dataValid,
   input  logic [SAMPLE_W-1:0] dataIn,
   input  logic [LEN_W-1:0]    dataLength,
   input  logic [7:0]          numEventsToAdd,
   output logic                dataRead,
   output logic [7:0]          txByte,
   output logic                txValid,
   input  logic                txReady,
   output logic                busy,
   output logic                packetDone,
   output logic                abortErr
);

   localparam int             SW        = $clog2(STALL_MAX + 1);
   localparam logic [SW-1:0]  STALL_LIM = SW'(STALL_MAX);
   localparam logic [SW-1:0]  STALL_ONE = SW'(1);

   txState_e            state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [7:0]          evt_q, evt_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic [7:0]          csum_q, csum_d;
   logic [SW-1:0]       stall_q, stall_d;
   logic                abort_q, abort_d;
   logic                done_q, done_d;
   logic                fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         rem_q    <= '0;
         evt_q    <= '0;
         sample_q <= '0;
         csum_q   <= '0;
         stall_q  <= '0;
         abort_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         rem_q    <= rem_d;
         evt_q    <= evt_d;
         sample_q <= sample_d;
         csum_q   <= csum_d;
         stall_q  <= stall_d;
         abort_q  <= abort_d;
         done_q   <= done_d;
      end
   end

   // The presented byte depends only on state, so it holds steady through txReady stalls.
   always_comb begin
      txValid = 1'b0;
      txByte  = 8'h00;
      unique case (state_q)
         S_HDR:     begin txValid = 1'b1; txByte = HDR_BYTE;          end
         S_LEN:     begin txValid = 1'b1; txByte = {1'b0, len_q};     end
         S_EVT:     begin txValid = 1'b1; txByte = evt_q;             end
         S_SEND_HI: begin txValid = 1'b1; txByte = sample_q[15:8];    end
         S_SEND_LO: begin txValid = 1'b1; txByte = sample_q[7:0];     end
         S_CSUM:    begin txValid = 1'b1; txByte = csum_q;            end
         default:   begin txValid = 1'b0; txByte = 8'h00;             end
      endcase
   end

   assign fire = txValid & txReady;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      rem_d    = rem_q;
      evt_d    = evt_q;
      sample_d = sample_q;
      csum_d   = csum_q;
      stall_d  = stall_q;
      abort_d  = abort_q;
      done_d   = 1'b0;
      dataRead = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (dataReadyToRead) begin
               len_d   = dataLength;
               rem_d   = dataLength;
               evt_d   = numEventsToAdd;
               csum_d  = 8'h00;
               abort_d = 1'b0;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            if (fire) state_d = S_LEN;
         end
         S_LEN: begin
            if (fire) begin
               csum_d  = csum_q ^ txByte;
               state_d = S_EVT;
            end
         end
         S_EVT: begin
            if (fire) begin
               csum_d  = csum_q ^ txByte;
               state_d = (len_q == '0) ? S_CSUM : S_FETCH;
            end
         end
         S_FETCH, S_WAITV: begin
            // The stall budget spans both the pop request and the read-latency wait.
            if (stall_q == STALL_LIM) begin
               abort_d = 1'b1;
               stall_d = '0;
               state_d = S_IDLE;
            end else begin
               stall_d = stall_q + STALL_ONE;
               if (state_q == S_FETCH) begin
                  if (dataReadyToRead) begin
                     dataRead = 1'b1;
                     state_d  = S_WAITV;
                  end
               end else if (dataValid) begin
                  sample_d = dataIn;
                  stall_d  = '0;
                  state_d  = S_SEND_HI;
               end
            end
         end
         S_SEND_HI: begin
            if (fire) begin
               csum_d  = csum_q ^ txByte;
               state_d = S_SEND_LO;
            end
         end
         S_SEND_LO: begin
            if (fire) begin
               csum_d  = csum_q ^ txByte;
               rem_d   = rem_q - 1'b1;
               state_d = (rem_q == 7'd1) ? S_CSUM : S_FETCH;
            end
         end
         S_CSUM: begin
            if (fire) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy       = (state_q != S_IDLE);
   assign packetDone = done_q;
   assign abortErr   = abort_q;

endmodule

// File: tb/tb_data_packet_tx.sv
// Directed self-checking bench for data_packet_tx: FIFO model with read latency 1,
// byte monitor on the tx handshake, and immediate-assertion checks per step.
module tb_data_packet_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dataReadyToRead = 1'b0;
   logic        dataValid = 1'b0;
   logic [15:0] dataIn = 16'h0000;
   logic [6:0]  dataLength = 7'd0;
   logic [7:0]  numEventsToAdd = 8'd0;
   logic        txReady = 1'b0;
   logic        dataRead;
   logic [7:0]  txByte;
   logic        txValid;
   logic        busy;
   logic        packetDone;
   logic        abortErr;

   int checks = 0;
   int errors = 0;

   logic [15:0] fifoQ[$];
   logic [7:0]  rxQ[$];
   bit          srcOn = 1'b1;
   bit          toggleMode = 1'b0;
   bit          readyLevel = 1'b1;
   bit          pendingPop = 1'b0;
   int          readCount = 0;
   int          doneCount = 0;
   int          stableErr = 0;
   logic        prevValid = 1'b0;
   logic        prevReady = 1'b0;
   logic [7:0]  prevByte = 8'h00;

   data_packet_tx dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .dataReadyToRead (dataReadyToRead),
      .dataValid       (dataValid),
      .dataIn          (dataIn),
      .dataLength      (dataLength),
      .numEventsToAdd  (numEventsToAdd),
      .dataRead        (dataRead),
      .txByte          (txByte),
      .txValid         (txValid),
      .txReady         (txReady),
      .busy            (busy),
      .packetDone      (packetDone),
      .abortErr        (abortErr)
   );

   always #5 clk = ~clk;

   // FIFO and transmitter model: inputs change 1 time unit after the rising edge.
   always @(posedge clk) begin
      #1;
      dataValid = pendingPop;
      if (pendingPop && fifoQ.size() > 0) dataIn = fifoQ.pop_front();
      pendingPop = 1'b0;
      dataReadyToRead = srcOn && (fifoQ.size() > 0);
      txReady = toggleMode ? ~txReady : readyLevel;
   end

   // Monitor on the falling edge: records transfers, pops, done pulses and byte stability.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dataRead) begin
            readCount++;
            pendingPop = 1'b1;
         end
         if (txValid && txReady) rxQ.push_back(txByte);
         if (packetDone) doneCount++;
         if (prevValid && !prevReady && (!txValid || txByte !== prevByte)) stableErr++;
      end
      prevValid = txValid && rst_n;
      prevReady = txReady;
      prevByte  = txByte;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] n, input logic [7:0] e);
      dataLength     = n;
      numEventsToAdd = e;
      rxQ.delete();
      readCount = 0;
      doneCount = 0;
      stableErr = 0;
   endtask

   task automatic waitDone(input string tag, input int limit);
      int i = 0;
      while (doneCount == 0 && i < limit) begin
         @(negedge clk);
         i++;
      end
      checkOutput({tag, " done"}, doneCount, 1);
      repeat (3) @(negedge clk);
      checkOutput({tag, " single done"}, doneCount, 1);
      @(posedge clk);
      #2;
   endtask

   task automatic checkStream(input string tag, input logic [7:0] exp[$]);
      checkOutput({tag, " length"}, rxQ.size(), exp.size());
      for (int i = 0; i < exp.size() && i < rxQ.size(); i++)
         checkOutput($sformatf("%s byte%0d", tag, i), rxQ[i], exp[i]);
   endtask

   initial begin
      logic [7:0] exp[$];
      int cyc;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset txValid", txValid, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset dataRead", dataRead, 0);
      checkOutput("reset packetDone", packetDone, 0);
      checkOutput("reset abortErr", abortErr, 0);
      checkOutput("reset txByte", txByte, 8'h00);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Two samples, transmitter always ready.
      applyStimulus(7'd2, 8'd4);
      fifoQ.push_back(16'h1234);
      fifoQ.push_back(16'hABCD);
      waitDone("pkt1", 200);
      exp = '{8'hA5, 8'h02, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h46};
      checkStream("pkt1", exp);
      checkOutput("pkt1 reads", readCount, 2);
      checkOutput("pkt1 abortErr", abortErr, 0);

      // Same packet with txReady toggling every cycle.
      toggleMode = 1'b1;
      applyStimulus(7'd2, 8'd4);
      fifoQ.push_back(16'h1234);
      fifoQ.push_back(16'hABCD);
      waitDone("pkt2", 300);
      checkStream("pkt2", exp);
      checkOutput("pkt2 reads", readCount, 2);
      checkOutput("pkt2 stable", stableErr, 0);
      toggleMode = 1'b0;
      readyLevel = 1'b1;

      // Empty record: a dummy entry starts the packet but must never be popped.
      applyStimulus(7'd0, 8'd1);
      fifoQ.push_back(16'hDEAD);
      cyc = 0;
      while (!busy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("pkt3 start", busy, 1);
      @(posedge clk);
      #2 srcOn = 1'b0;
      waitDone("pkt3", 100);
      exp = '{8'hA5, 8'h00, 8'h01, 8'h01};
      checkStream("pkt3", exp);
      checkOutput("pkt3 reads", readCount, 0);
      checkOutput("pkt3 fifo untouched", fifoQ.size(), 1);
      fifoQ.delete();
      srcOn = 1'b1;

      // FIFO runs dry after one sample and refills 40 cycles later.
      applyStimulus(7'd3, 8'd7);
      fifoQ.push_back(16'h0102);
      cyc = 0;
      while (readCount == 0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("pkt4 first pop", readCount, 1);
      repeat (40) @(negedge clk);
      checkOutput("pkt4 holding busy", busy, 1);
      checkOutput("pkt4 holding txValid", txValid, 0);
      checkOutput("pkt4 holding reads", readCount, 1);
      @(posedge clk);
      #2;
      fifoQ.push_back(16'h0304);
      fifoQ.push_back(16'h0506);
      waitDone("pkt4", 200);
      exp = '{8'hA5, 8'h03, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h03};
      checkStream("pkt4", exp);
      checkOutput("pkt4 reads", readCount, 3);
      checkOutput("pkt4 abortErr", abortErr, 0);

      // FIFO never refills: stall timeout aborts the packet.
      applyStimulus(7'd3, 8'h09);
      fifoQ.push_back(16'hFFFF);
      cyc = 0;
      while (readCount == 0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("abort first pop", readCount, 1);
      cyc = 0;
      while (!abortErr && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("abort raised", abortErr, 1);
      checkOutput("abort timing", (cyc >= 1000 && cyc <= 1100), 1);
      checkOutput("abort txValid", txValid, 0);
      checkOutput("abort idle", busy, 0);
      checkOutput("abort no done", doneCount, 0);
      exp = '{8'hA5, 8'h03, 8'h09, 8'hFF, 8'hFF};
      checkStream("abort partial", exp);
      repeat (5) @(negedge clk);
      checkOutput("abort sticky", abortErr, 1);
      @(posedge clk);
      #2;

      // Next packet clears the sticky abort.
      applyStimulus(7'd1, 8'd0);
      fifoQ.push_back(16'h00FF);
      cyc = 0;
      while (!busy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("pkt6 start", busy, 1);
      checkOutput("pkt6 abort cleared", abortErr, 0);
      waitDone("pkt6", 200);
      exp = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'hFF, 8'hFE};
      checkStream("pkt6", exp);

      // Asynchronous reset while the low byte of the first sample is on the bus.
      applyStimulus(7'd2, 8'd4);
      fifoQ.push_back(16'h1234);
      fifoQ.push_back(16'hABCD);
      cyc = 0;
      while (!(txValid && txByte == 8'h34) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("rst reached SEND_LO", txByte, 8'h34);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst txValid", txValid, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst txByte", txByte, 8'h00);
      checkOutput("rst dataRead", dataRead, 0);
      checkOutput("rst packetDone", packetDone, 0);
      @(posedge clk);
      #2;
      fifoQ.delete();
      pendingPop = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      applyStimulus(7'd1, 8'd2);
      fifoQ.push_back(16'h5566);
      waitDone("pkt7", 200);
      exp = '{8'hA5, 8'h01, 8'h02, 8'h55, 8'h66, 8'h30};
      checkStream("pkt7", exp);
      checkOutput("pkt7 reads", readCount, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
